thermostat_ctrl: RTL and testbench

Control stage directly downstream of the temperature comparator. It consumes the comparator's greater/equal/lower flags (measured temperature vs. setpoint), qualified by a sample strobe. It debounces them over consecutive samples and runs a heat/cool state machine with minimum-run and dead-time timers. It drives the heater and cooler enables of the temperature control system.

---
 rtl/thermostat_pkg.sv | 19 +
 rtl/sample_confirm.sv | 68 ++++++
 rtl/thermostat_ctrl.sv | 97 +++++++++
 tb/tb_thermostat_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thermostat_pkg.sv
// Shared encodings for the thermostat control stage.
// State and comparator-direction codes are 2 bits wide.
package thermostat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    DEAD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LOW  = 2'd1,
    EQ   = 2'd2,
    HIGH = 2'd3
  } dir_t;

endpackage

// File: rtl/sample_confirm.sv
// Debounce filter for the comparator flags: validity check,
// direction tracking, saturating count, registered verdict.
module sample_confirm
  import thermostat_pkg::*;
#(
  parameter int CONFIRM_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_valid,
  input  logic input_greater,
  input  logic input_equal,
  input  logic input_lower,
  output dir_t confirmed,
  output logic flag_error
);

  localparam int CW = $clog2(CONFIRM_SAMPLES + 1);
  localparam logic [CW-1:0] FULL = CW'(CONFIRM_SAMPLES);

  dir_t          last_dir;
  dir_t          dir;
  dir_t          next_dir;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic          valid;

  always_comb begin
    valid      = $onehot({input_greater, input_equal, input_lower});
    dir        = EQ;
    next_dir   = last_dir;
    next_count = count;
    if (valid) begin
      unique case (1'b1)
        input_greater: dir = HIGH;
        input_equal:   dir = EQ;
        input_lower:   dir = LOW;
        default:       dir = EQ;
      endcase
    end
    if (sample_valid) begin
      if (!valid) begin
        next_count = '0;
      end else if (dir == last_dir) begin
        if (count != FULL) next_count = count + CW'(1);
      end else begin
        next_dir   = dir;
        next_count = CW'(1);
      end
    end
  end

  // Verdict uses next-state values so it is valid the cycle after the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dir   <= EQ;
      count      <= '0;
      confirmed  <= NONE;
      flag_error <= 1'b0;
    end else begin
      last_dir   <= next_dir;
      count      <= next_count;
      confirmed  <= (next_count == FULL) ? next_dir : NONE;
      flag_error <= sample_valid && !valid;
    end
  end

endmodule

// File: rtl/thermostat_ctrl.sv
// Heat/cool controller: debounced direction drives an FSM with
// minimum-run and dead-time phases sharing a single timer.
module thermostat_ctrl
  import thermostat_pkg::*;
#(
  parameter int CONFIRM_SAMPLES = 4,
  parameter int MIN_RUN_CYCLES  = 1000,
  parameter int DEAD_CYCLES     = 100,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic       input_greater,
  input  logic       input_equal,
  input  logic       input_lower,
  output logic       heater_on,
  output logic       cooler_on,
  output logic [1:0] ctrl_state,
  output logic       flag_error
);

  localparam logic [CNT_WIDTH-1:0] RUN_MAX  = CNT_WIDTH'(MIN_RUN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DEAD_MAX = CNT_WIDTH'(DEAD_CYCLES);

  state_t               state;
  logic [CNT_WIDTH-1:0] timer;
  dir_t                 confirmed;

  sample_confirm #(
    .CONFIRM_SAMPLES(CONFIRM_SAMPLES)
  ) u_confirm (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .input_greater(input_greater),
    .input_equal  (input_equal),
    .input_lower  (input_lower),
    .confirmed    (confirmed),
    .flag_error   (flag_error)
  );

  // Run and dead phases never overlap, so one timer serves both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (enable && confirmed == LOW) begin
            state <= HEAT;
          end else if (enable && confirmed == HIGH) begin
            state <= COOL;
          end
        end
        HEAT: begin
          if (!enable || (timer == RUN_MAX &&
              (confirmed == EQ || confirmed == HIGH))) begin
            state <= DEAD;
            timer <= '0;
          end else if (timer != RUN_MAX) begin
            timer <= timer + CNT_WIDTH'(1);
          end
        end
        COOL: begin
          if (!enable || (timer == RUN_MAX &&
              (confirmed == EQ || confirmed == LOW))) begin
            state <= DEAD;
            timer <= '0;
          end else if (timer != RUN_MAX) begin
            timer <= timer + CNT_WIDTH'(1);
          end
        end
        DEAD: begin
          if (timer == DEAD_MAX) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign heater_on  = (state == HEAT);
  assign cooler_on  = (state == COOL);
  assign ctrl_state = state;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Scenario tasks plus a randomized run, all checked against a
// sample-history / phase-age model of the thermostat behaviour.
module tb_thermostat_ctrl;

  localparam int CS = 3;
  localparam int MR = 8;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sample_valid = 1'b0;
  logic       input_greater = 1'b0;
  logic       input_equal = 1'b0;
  logic       input_lower = 1'b0;
  logic       heater_on;
  logic       cooler_on;
  logic [1:0] ctrl_state;
  logic       flag_error;

  int total = 0;
  int passed = 0;

  // model: 0 idle, 1 heat, 2 cool, 3 dead; directions 1 low, 2 eq, 3 high
  int m_state = 0;
  int m_age = 0;
  int m_conf = 0;
  bit m_err = 1'b0;
  int hist[$];

  always #5 clk = ~clk;

  thermostat_ctrl #(
    .CONFIRM_SAMPLES(CS),
    .MIN_RUN_CYCLES (MR),
    .DEAD_CYCLES    (DC),
    .CNT_WIDTH      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .input_greater(input_greater),
    .input_equal  (input_equal),
    .input_lower  (input_lower),
    .heater_on    (heater_on),
    .cooler_on    (cooler_on),
    .ctrl_state   (ctrl_state),
    .flag_error   (flag_error)
  );

  function automatic logic [4:0] dut_vec();
    return {heater_on, cooler_on, ctrl_state, flag_error};
  endfunction

  function automatic logic [4:0] mod_vec();
    return {m_state == 1, m_state == 2, 2'(m_state), m_err};
  endfunction

  task automatic model(bit r, bit en, bit sv, bit g, bit e, bit l);
    int oc;
    if (r) begin
      m_state = 0;
      m_age = 0;
      m_conf = 0;
      m_err = 1'b0;
      hist.delete();
      return;
    end
    oc = m_conf;
    m_err = sv && (int'(g) + int'(e) + int'(l) != 1);
    if (sv) begin
      if (m_err) hist.delete();
      else begin
        hist.push_back(g ? 3 : (e ? 2 : 1));
        if (hist.size() > CS) void'(hist.pop_front());
      end
    end
    // confirmed when the last CS valid samples all agree
    m_conf = 0;
    if (hist.size() == CS) begin
      m_conf = hist[0];
      foreach (hist[i]) if (hist[i] != hist[0]) m_conf = 0;
    end
    case (m_state)
      0: begin
        if (en && oc == 1) begin m_state = 1; m_age = 0; end
        else if (en && oc == 3) begin m_state = 2; m_age = 0; end
      end
      1: begin
        if (!en || (m_age >= MR && (oc == 2 || oc == 3))) begin
          m_state = 3; m_age = 0;
        end else m_age++;
      end
      2: begin
        if (!en || (m_age >= MR && (oc == 2 || oc == 1))) begin
          m_state = 3; m_age = 0;
        end else m_age++;
      end
      default: begin
        if (m_age == DC) begin m_state = 0; m_age = 0; end
        else m_age++;
      end
    endcase
  endtask

  // d: 0 no sample, 1 lower, 2 equal, 3 greater, 4 invalid (greater+lower)
  task automatic step(bit r, bit en, int d);
    rst = r;
    enable = en;
    sample_valid = (d != 0);
    input_lower = (d == 1 || d == 4);
    input_equal = (d == 2);
    input_greater = (d == 3 || d == 4);
    @(posedge clk);
    model(r, en, sample_valid, input_greater, input_equal, input_lower);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 3);
    total++;
    if (dut_vec() !== 5'b0) begin
      $display("FAIL reset: got %b exp 00000", dut_vec());
    end else passed++;
    step(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_heat();
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1);
      total++;
      if (dut_vec() !== mod_vec() || heater_on !== 1'b0) begin
        $display("FAIL heat_pre: got %b exp %b", dut_vec(), mod_vec());
      end else passed++;
    end
    step(1'b0, 1'b1, 0);
    total++;
    if (heater_on !== 1'b1 || cooler_on !== 1'b0 || ctrl_state !== 2'd1) begin
      $display("FAIL heat_entry: got h=%b c=%b s=%0d exp 1 0 1",
               heater_on, cooler_on, ctrl_state);
    end else passed++;
  endtask

  task automatic test_debounce();
    int seq[7] = '{1, 1, 3, 1, 1, 0, 0};
    step(1'b1, 1'b0, 0);
    foreach (seq[i]) begin
      step(1'b0, 1'b1, seq[i]);
      total++;
      if (ctrl_state !== 2'd0 || dut_vec() !== mod_vec()) begin
        $display("FAIL debounce_hold: got %b exp state 0 (%b)",
                 dut_vec(), mod_vec());
      end else passed++;
    end
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 0);
    total++;
    if (ctrl_state !== 2'd1 || heater_on !== 1'b1) begin
      $display("FAIL debounce_heat: got s=%0d h=%b exp 1 1",
               ctrl_state, heater_on);
    end else passed++;
  endtask

  task automatic test_min_run_dead();
    int ones = 1;
    int dead = 0;
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, (i < 3) ? 2 : 0);
      total++;
      if (dut_vec() !== mod_vec()) begin
        $display("FAIL minrun_model: got %b exp %b", dut_vec(), mod_vec());
      end else passed++;
      if (ctrl_state == 2'd1) ones++;
      if (ctrl_state == 2'd3) begin
        dead++;
        if (heater_on || cooler_on) ones += 100;
      end
    end
    total++;
    if (ones != MR + 1) begin
      $display("FAIL minrun_len: got %0d exp %0d", ones, MR + 1);
    end else passed++;
    total++;
    if (dead != DC + 1 || ctrl_state !== 2'd0) begin
      $display("FAIL dead_len: got %0d/s=%0d exp %0d/0",
               dead, ctrl_state, DC + 1);
    end else passed++;
  endtask

  task automatic test_invalid();
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 4);
    total++;
    if (flag_error !== 1'b1) begin
      $display("FAIL err_pulse: got %b exp 1", flag_error);
    end else passed++;
    step(1'b0, 1'b1, 0);
    total++;
    if (flag_error !== 1'b0) begin
      $display("FAIL err_width: got %b exp 0", flag_error);
    end else passed++;
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 0);
      total++;
      if (ctrl_state !== 2'd0 || dut_vec() !== mod_vec()) begin
        $display("FAIL err_restart: got %b exp state 0 (%b)",
                 dut_vec(), mod_vec());
      end else passed++;
    end
  endtask

  task automatic test_enable_drop();
    int dead = 1;
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 0);
    total++;
    if (cooler_on !== 1'b1 || ctrl_state !== 2'd2) begin
      $display("FAIL cool_entry: got c=%b s=%0d exp 1 2",
               cooler_on, ctrl_state);
    end else passed++;
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    total++;
    if (cooler_on !== 1'b0 || ctrl_state !== 2'd3) begin
      $display("FAIL en_drop: got c=%b s=%0d exp 0 3",
               cooler_on, ctrl_state);
    end else passed++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 0);
      if (ctrl_state == 2'd3) dead++;
      total++;
      if (dut_vec() !== mod_vec()) begin
        $display("FAIL en_drop_model: got %b exp %b", dut_vec(), mod_vec());
      end else passed++;
    end
    total++;
    if (dead != DC + 1 || ctrl_state !== 2'd0) begin
      $display("FAIL en_idle_hold: got dead=%0d s=%0d exp %0d 0",
               dead, ctrl_state, DC + 1);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 0);
    total++;
    if (heater_on !== 1'b0 || ctrl_state !== 2'd0) begin
      $display("FAIL rst_mid: got h=%b s=%0d exp 0 0", heater_on, ctrl_state);
    end else passed++;
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 0);
      total++;
      if (ctrl_state !== 2'd0) begin
        $display("FAIL rst_fresh: got s=%0d exp 0", ctrl_state);
      end else passed++;
    end
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 0);
    total++;
    if (heater_on !== 1'b1 || ctrl_state !== 2'd1) begin
      $display("FAIL rst_reheat: got h=%b s=%0d exp 1 1",
               heater_on, ctrl_state);
    end else passed++;
  endtask

  task automatic test_random();
    int dir = 1;
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit en;
      int d;
      r = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) dir = $urandom_range(1, 3);
      d = 0;
      if ($urandom_range(0, 1) == 1) begin
        d = ($urandom_range(0, 29) == 0) ? 4 : dir;
      end
      step(r, en, d);
      total++;
      if (dut_vec() !== mod_vec() || (heater_on && cooler_on)) begin
        $display("FAIL random[%0d]: got %b exp %b", i, dut_vec(), mod_vec());
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_heat();
    test_debounce();
    test_min_run_dead();
    test_invalid();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
